wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single beta-side register-file write port between the in-order beta pipe (requester 0) and out-of-order result producers: mul/div unit, load-miss return (requesters 1..NUM_REQ-1).
- Sits between those producers and the register file, replacing the direct writeback pass-through.
- Requester 0 has fixed priority; the others are round-robin with a starvation guard that stalls the pipe.
- Registered output gives a fixed one-cycle write latency.

Parameters:
- NUM_REQ, 3, number of requesters (≥2); index 0 is the in-order pipe.
- STARVE_LIMIT, 4, consecutive cycles a waiting secondary requester may be denied before it is forced through (≥1).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester write request.
- req_dest  input  NUM_REQ×5  per-requester destination register, packed, requester i at [5i+4:5i].
- req_data  input  NUM_REQ×32  per-requester result, packed, requester i at [32i+31:32i].
- req_ready  output  NUM_REQ  per-requester accept; req_ready[0] low is the pipe stall.
- reg_write_en  output  1  register-file write enable.
- reg_write_dest  output  5  register-file write address.
- reg_write_data  output  32  register-file write data.

Behaviour:
- Handshake
  - Transfer on req_valid[i] && req_ready[i].
  - A requester holds valid, dest and data stable until accepted; valid must not depend on ready.
  - req_ready is combinational from req_valid, rr_ptr and starve_cnt; at most one bit is high per cycle.
  - req_ready[i] is 0 whenever req_valid[i] is 0.
- Grant selection, each cycle, in priority order:
  1. If starve_cnt == STARVE_LIMIT and any req_valid[1..] is set: grant the round-robin winner among 1..NUM_REQ-1; req_ready[0]=0 even if req_valid[0].
  2. Else if req_valid[0]: grant 0.
  3. Else grant the round-robin winner among 1..NUM_REQ-1, if any is valid.
  4. Else no grant.
- Round-robin
  - rr_ptr ranges over 1..NUM_REQ-1.
  - Winner is the first valid requester at or after rr_ptr, wrapping from NUM_REQ-1 to 1 (0 is never in the ring).
  - On a grant to i≥1, rr_ptr ← i+1, wrapping to 1.
  - rr_ptr is unchanged on a grant to 0 or no grant.
- Starvation counter, width $clog2(STARVE_LIMIT+1):
  - Reset to 0 on any grant to i≥1, or when no req_valid[1..] is set.
  - Otherwise increments, saturating at STARVE_LIMIT.
- Output pipeline
  - Transfer in cycle t drives reg_write_en/dest/data at the t+1 edge, held for exactly one cycle.
  - With no transfer in t, reg_write_en=0 at t+1; dest and data hold their last values.
- Destination zero: the request is accepted normally, but reg_write_en=0 in the next cycle. It still counts as a grant for rr_ptr and starve_cnt.
- Throughput: one write per cycle; back-to-back grants to the same requester are allowed.
- Reset (async)
  - reg_write_en=0, reg_write_dest=0, reg_write_data=0, rr_ptr=1, starve_cnt=0.
  - Reset mid-operation discards a registered but undelivered write; in-flight requesters restart their handshake after reset.
  - req_ready stays 0 while rst is high.

Decomposition:
- Shared package sirius_wb_pkg:
  - REG_ADDR_W=5, DATA_W=32.
  - typedef wb_req_t {dest, data}.
  - Requester index constants WB_REQ_PIPE=0, WB_REQ_MDU=1, WB_REQ_LSU=2.
- Sub-module rr_arbiter: parameterised width, purely combinational.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded winner index.
  - Instantiated over requesters 1..NUM_REQ-1.
- Starvation counter, priority override and output register stay in wb_port_arbiter.

Test Plan:
1. Reset with all valids high → all req_ready=0 and reg_write_en=0 while rst=1; first cycle after deassert grants 0; next cycle reg_write_en=1, dest and data of requester 0.
2. Only requester 0 valid, dest=5, data=32'hDEADBEEF, for 3 cycles → req_ready=3'b001 each cycle; reg_write_en=1, dest=5, data=DEADBEEF on cycles 1–3.
3. Requesters 1 and 2 continuously valid, 0 idle → grants alternate 1,2,1,2 starting with 1 after reset; starve_cnt stays 0.
4. Requesters 0 and 1 continuously valid, STARVE_LIMIT=4 → 0 granted 4 cycles; cycle 5 req_ready=3'b010 (pipe stalled); cycle 6 back to 3'b001; pattern repeats every 5 cycles.
5. Requester 1 with dest=0, data=32'h1234 → req_ready[1]=1; next cycle reg_write_en=0; rr_ptr advances to 2.
6. Reset asserted the cycle after an accepted write of dest=7 → reg_write_en drops to 0 asynchronously; no write to r7 occurs.

Source files
------------

// File: rtl/sirius_wb_pkg.sv
// rtl/sirius_wb_pkg.sv - shared register-file writeback types and requester indices
package sirius_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    // Requester slots on the beta-side writeback port
    localparam int WB_REQ_PIPE = 0;
    localparam int WB_REQ_MDU  = 1;
    localparam int WB_REQ_LSU  = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
//   req   : request vector, one bit per ring slot
//   ptr   : slot that has first claim this cycle (0..N-1)
//   grant : one-hot winner, zero when no request
//   idx   : encoded winner, zero when no request
//   valid : any request present
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        // Walk the ring from ptr; the first requesting slot wins.
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (!valid && req[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares the register-file write port between the pipe and OoO producers
//   clk, rst        : clock, asynchronous active-high reset
//   req_valid       : per-requester write request (0 = in-order pipe)
//   req_dest        : per-requester destination, requester i at [5i+4:5i]
//   req_data        : per-requester result, requester i at [32i+31:32i]
//   req_ready       : per-requester accept; req_ready[0] low stalls the pipe
//   reg_write_*     : registered register-file write, one cycle after the transfer
module wb_port_arbiter
    import sirius_wb_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_dest,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          reg_write_en,
    output logic [REG_ADDR_W-1:0]         reg_write_dest,
    output logic [DATA_W-1:0]             reg_write_data
);

    localparam int NUM_SEC = NUM_REQ - 1;
    localparam int SEC_W   = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;
    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int CNT_W   = $clog2(STARVE_LIMIT + 1);

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic                  reg_write_en_q, reg_write_en_d;
    logic [REG_ADDR_W-1:0] reg_write_dest_q, reg_write_dest_d;
    logic [DATA_W-1:0]     reg_write_data_q, reg_write_data_d;

    logic [NUM_SEC-1:0]    sec_req;
    logic [NUM_SEC-1:0]    sec_grant;
    logic [SEC_W-1:0]      sec_ptr;
    logic [SEC_W-1:0]      sec_idx;
    logic                  sec_any;
    logic                  starve_hit;
    logic                  grant_pipe;
    logic                  grant_sec;
    logic                  transfer;
    logic [PTR_W-1:0]      win_idx;
    wb_req_t               sel;

    // The ring covers requesters 1..NUM_REQ-1; rr_ptr is kept in requester
    // numbering, so shift it down by one for the ring-local arbiter.
    assign sec_req = req_valid[NUM_REQ-1:1];
    assign sec_ptr = SEC_W'(rr_ptr_q - PTR_W'(1));

    rr_arbiter #(
        .N     (NUM_SEC),
        .IDX_W (SEC_W)
    ) u_rr_arbiter (
        .req   (sec_req),
        .ptr   (sec_ptr),
        .grant (sec_grant),
        .idx   (sec_idx),
        .valid (sec_any)
    );

    assign starve_hit = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    // Grant selection: a starved secondary overrides the pipe, otherwise the
    // pipe has fixed priority, otherwise the round-robin winner goes.
    always_comb begin
        grant_pipe = 1'b0;
        grant_sec  = 1'b0;
        req_ready  = '0;
        if (!rst) begin
            if (starve_hit && sec_any) begin
                grant_sec = 1'b1;
            end else if (req_valid[WB_REQ_PIPE]) begin
                grant_pipe = 1'b1;
            end else if (sec_any) begin
                grant_sec = 1'b1;
            end
        end
        req_ready[WB_REQ_PIPE] = grant_pipe;
        if (grant_sec) begin
            req_ready[NUM_REQ-1:1] = sec_grant;
        end
    end

    assign transfer = grant_pipe | grant_sec;
    assign win_idx  = PTR_W'(sec_idx) + PTR_W'(1);

    // Pointer moves just past a secondary winner; the pipe never touches it.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_sec) begin
            if (win_idx == PTR_W'(NUM_REQ - 1)) begin
                rr_ptr_d = PTR_W'(1);
            end else begin
                rr_ptr_d = win_idx + PTR_W'(1);
            end
        end
    end

    // Counts cycles a secondary has been waiting without any secondary grant.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_sec || !sec_any) begin
            starve_cnt_d = '0;
        end else if (!starve_hit) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel.dest = req_dest[i*REG_ADDR_W +: REG_ADDR_W];
                sel.data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // r0 is hardwired zero: accept the transfer but suppress the write.
    always_comb begin
        reg_write_en_d   = transfer && (sel.dest != '0);
        reg_write_dest_d = reg_write_dest_q;
        reg_write_data_d = reg_write_data_q;
        if (transfer) begin
            reg_write_dest_d = sel.dest;
            reg_write_data_d = sel.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q         <= PTR_W'(1);
            starve_cnt_q     <= '0;
            reg_write_en_q   <= 1'b0;
            reg_write_dest_q <= '0;
            reg_write_data_q <= '0;
        end else begin
            rr_ptr_q         <= rr_ptr_d;
            starve_cnt_q     <= starve_cnt_d;
            reg_write_en_q   <= reg_write_en_d;
            reg_write_dest_q <= reg_write_dest_d;
            reg_write_data_q <= reg_write_data_d;
        end
    end

    assign reg_write_en   = reg_write_en_q;
    assign reg_write_dest = reg_write_dest_q;
    assign reg_write_data = reg_write_data_q;

endmodule
